// File: rtl/muldiv_unit_if.sv
// Operand/request and register-file writeback bundle for the iterative multiply/divide unit.
// The pipeline side drives the master modport and the execution unit takes the slave modport.
interface muldiv_unit_if #(
    parameter int WIDTH = 32,
    parameter int REG_W = 5
);
    logic             start;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] rs1_val;
    logic [WIDTH-1:0] rs2_val;
    logic [REG_W-1:0] rd;
    logic             kill;
    logic             busy;
    logic             wb_we;
    logic [REG_W-1:0] wb_dst;
    logic [WIDTH-1:0] wb_data;

    modport master (
        output start, funct3, rs1_val, rs2_val, rd, kill,
        input  busy, wb_we, wb_dst, wb_data
    );

    modport slave (
        input  start, funct3, rs1_val, rs2_val, rd, kill,
        output busy, wb_we, wb_dst, wb_data
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: a shift-add multiply or restoring divide on operand
// magnitudes, with a fixed latency of 33 cycles from accept to the one-cycle writeback.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int REG_W = 5
) (
    input logic          clk,
    input logic          reset,
    muldiv_unit_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [2:0]         op_q, op_d;
    logic [REG_W-1:0]   rd_q, rd_d;
    logic               neg_q, neg_d;
    logic               busy_q, busy_d;
    logic               wb_we_q, wb_we_d;
    logic [REG_W-1:0]   wb_dst_q, wb_dst_d;
    logic [WIDTH-1:0]   wb_data_q, wb_data_d;

    logic               a_signed, b_signed, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum, rem_sh, rem_diff;
    logic [WIDTH-1:0]   rem_new;
    logic [2*WIDTH-1:0] acc_step, prod_signed;
    logic [WIDTH-1:0]   div_sel, result;

    // Operand signedness per funct3: MULH/DIV/REM are signed*signed, MULHSU is signed*unsigned.
    always_comb begin
        a_signed = (bus.funct3 == 3'd1) || (bus.funct3 == 3'd2) ||
                   (bus.funct3 == 3'd4) || (bus.funct3 == 3'd6);
        b_signed = (bus.funct3 == 3'd1) || (bus.funct3 == 3'd4) || (bus.funct3 == 3'd6);
        a_neg    = a_signed && bus.rs1_val[WIDTH-1];
        b_neg    = b_signed && bus.rs2_val[WIDTH-1];
        a_mag    = a_neg ? (~bus.rs1_val + 1'b1) : bus.rs1_val;
        b_mag    = b_neg ? (~bus.rs2_val + 1'b1) : bus.rs2_val;
    end

    // acc_q holds {partial product, multiplier} for multiply and {remainder, dividend} for divide.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, opb_q};
        rem_new  = rem_diff[WIDTH] ? rem_sh[WIDTH-1:0] : rem_diff[WIDTH-1:0];
        if (op_q[2]) begin
            acc_step = {rem_new, acc_q[WIDTH-2:0], ~rem_diff[WIDTH]};
        end else begin
            acc_step = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod_signed = neg_q ? (~acc_step + 1'b1) : acc_step;
        div_sel     = op_q[1] ? acc_step[2*WIDTH-1:WIDTH] : acc_step[WIDTH-1:0];
        if (op_q[2]) begin
            result = neg_q ? (~div_sel + 1'b1) : div_sel;
        end else if (op_q[1:0] == 2'd0) begin
            result = prod_signed[WIDTH-1:0];
        end else begin
            result = prod_signed[2*WIDTH-1:WIDTH];
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        op_d      = op_q;
        rd_d      = rd_q;
        neg_d     = neg_q;
        busy_d    = busy_q;
        wb_we_d   = 1'b0;
        wb_dst_d  = wb_dst_q;
        wb_data_d = wb_data_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.kill) begin
                    state_d = S_CALC;
                    count_d = '0;
                    op_d    = bus.funct3;
                    rd_d    = bus.rd;
                    busy_d  = 1'b1;
                    if (bus.funct3[2]) begin
                        acc_d = {{WIDTH{1'b0}}, a_mag};
                        opb_d = b_mag;
                        // Remainder follows the dividend; a zero divisor keeps the all-ones quotient.
                        neg_d = bus.funct3[1] ? a_neg : ((a_neg ^ b_neg) && (bus.rs2_val != '0));
                    end else begin
                        acc_d = {{WIDTH{1'b0}}, b_mag};
                        opb_d = a_mag;
                        neg_d = a_neg ^ b_neg;
                    end
                end
            end
            S_CALC: begin
                if (bus.kill) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    acc_d   = acc_step;
                    count_d = count_q + 1'b1;
                    if (count_q == CNT_W'(WIDTH - 1)) begin
                        state_d   = S_DONE;
                        wb_we_d   = 1'b1;
                        wb_dst_d  = rd_q;
                        wb_data_d = result;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            op_q      <= '0;
            rd_q      <= '0;
            neg_q     <= 1'b0;
            busy_q    <= 1'b0;
            wb_we_q   <= 1'b0;
            wb_dst_q  <= '0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            neg_q     <= neg_d;
            busy_q    <= busy_d;
            wb_we_q   <= wb_we_d;
            wb_dst_q  <= wb_dst_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.wb_we   = wb_we_q;
    assign bus.wb_dst  = wb_dst_q;
    assign bus.wb_data = wb_data_q;
endmodule
